// File: rtl/fifo_pack_pkg.sv
// Shared defaults and elaboration-time helpers for the token-packing FIFO.
package fifo_pack_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_RATIO = 2;
  localparam int unsigned DEF_DEPTH = 4;

  // Ceiling log2; clog2(1) = 0, used for both pointer and count widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_pack_mem.sv
// Packed-word storage: synchronous write, asynchronous read, no reset.
module fifo_pack_mem
  import fifo_pack_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH * DEF_RATIO,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                      ck,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge ck) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/fifo_pack.sv
// Packs RATIO input tokens into one word and queues DEPTH words, first-word-fall-through.
module fifo_pack
  import fifo_pack_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RATIO = DEF_RATIO,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        ck,
  input  logic                        rst,
  input  logic                        wr,
  input  logic [WIDTH-1:0]            datain,
  output logic                        full,
  input  logic                        rd,
  output logic                        empty,
  output logic [WIDTH*RATIO-1:0]      dataout,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam int unsigned SW = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam int unsigned WW = WIDTH * RATIO;
  localparam logic [SW-1:0] LAST_SLOT = SW'(RATIO - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] slot_q;
  logic [WW-1:0] pack_q;
  logic [WW-1:0] word_d;
  logic [WW-1:0] head_word;
  logic          wr_ok, complete, pop;

  // full only blocks the completing token, so partial tokens still land while count=DEPTH.
  always_comb begin
    full     = (count_q == FULL_CNT) && (slot_q == LAST_SLOT);
    empty    = (count_q == '0);
    wr_ok    = wr && !full;
    complete = wr_ok && (slot_q == LAST_SLOT);
    pop      = rd && !empty;
    count    = count_q;
    dataout  = empty ? '0 : head_word;
  end

  // The incoming token is merged into its slot; on the last slot this is the finished word.
  always_comb begin
    word_d = pack_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (SW'(k) == slot_q) word_d[k*WIDTH +: WIDTH] = datain;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slot_q   <= '0;
      pack_q   <= '0;
    end else begin
      if (wr_ok) begin
        if (complete) begin
          slot_q <= '0;
        end else begin
          slot_q <= slot_q + SW'(1);
          pack_q <= word_d;
        end
      end
      if (complete) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({complete, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  fifo_pack_mem #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_mem (
    .ck    (ck),
    .we    (complete),
    .waddr (wr_ptr_q),
    .wdata (word_d),
    .raddr (rd_ptr_q),
    .rdata (head_word)
  );

endmodule

// File: tb/tb_fifo_pack.sv
// Self-checking bench for fifo_pack: directed scenarios plus a randomized run against a queue model.
module tb_fifo_pack;

  localparam int W = 8;
  localparam int R = 2;
  localparam int D = 4;

  logic          ck = 1'b0;
  logic          rst, wr, rd;
  logic [W-1:0]  datain;
  logic          full, empty;
  logic [W*R-1:0] dataout;
  logic [2:0]    count;

  fifo_pack #(.WIDTH(W), .RATIO(R), .DEPTH(D)) dut (
    .ck(ck), .rst(rst), .wr(wr), .datain(datain), .full(full),
    .rd(rd), .empty(empty), .dataout(dataout), .count(count)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of completed words plus pending tokens.
  logic [W*R-1:0] mq[$];
  logic [W-1:0]   part[R];
  int             slot = 0;

  task automatic cycle(input logic r_st, input logic w, input logic [W-1:0] d, input logic r);
    bit m_full, m_pop;
    logic [W*R-1:0] word;
    rst = r_st; wr = w; datain = d; rd = r;
    m_full = (mq.size() == D) && (slot == R - 1);
    m_pop  = r && (mq.size() > 0);
    @(posedge ck);
    if (r_st) begin
      mq.delete();
      slot = 0;
    end else begin
      if (m_pop) mq.delete(0);
      if (w && !m_full) begin
        part[slot] = d;
        if (slot == R - 1) begin
          for (int k = 0; k < R; k++) word[k*W +: W] = part[k];
          mq.push_back(word);
          slot = 0;
        end else begin
          slot++;
        end
      end
    end
    #1;
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (dataout !== 16'h0000) begin errors++; $display("FAIL reset_dataout: got %h want 0000", dataout); end
  endtask

  task automatic test_pack_read();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h11, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pack_partial_hidden: empty got %b want 1", empty); end
    cycle(1'b0, 1'b1, 8'h22, 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pack_empty: got %b want 0", empty); end
    checks++; if (dataout !== 16'h2211) begin errors++; $display("FAIL pack_dataout: got %h want 2211", dataout); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL pack_count: got %0d want 1", count); end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pack_pop_empty: got %b want 1", empty); end
    checks++; if (dataout !== 16'h0000) begin errors++; $display("FAIL pack_pop_dataout: got %h want 0000", dataout); end
  endtask

  task automatic test_fill_full();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_not_full: got %b want 0", full); end
    cycle(1'b0, 1'b1, 8'h09, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (dut.slot_q !== 1'b1) begin errors++; $display("FAIL fill_slot: got %0d want 1", dut.slot_q); end
    cycle(1'b0, 1'b1, 8'h0A, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count: got %0d want 4", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL drop_full: got %b want 1", full); end
    checks++; if (dut.slot_q !== 1'b1) begin errors++; $display("FAIL drop_slot: got %0d want 1", dut.slot_q); end
    checks++; if (dut.pack_q[7:0] !== 8'h09) begin errors++; $display("FAIL drop_pack: got %h want 09", dut.pack_q[7:0]); end
    checks++; if (dataout !== 16'h0201) begin errors++; $display("FAIL drop_head: got %h want 0201", dataout); end
  endtask

  task automatic test_drain();
    logic [15:0] exp_w[4];
    exp_w[0] = 16'h0201; exp_w[1] = 16'h0403; exp_w[2] = 16'h0605; exp_w[3] = 16'h0807;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dataout !== exp_w[i]) begin errors++; $display("FAIL drain_word%0d: got %h want %h", i, dataout, exp_w[i]); end
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    checks++; if (dut.rd_ptr_q !== 2'd0) begin errors++; $display("FAIL drain_rdptr_wrap: got %0d want 0", dut.rd_ptr_q); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_w[4];
    exp_w[0] = 16'h0403; exp_w[1] = 16'h0605; exp_w[2] = 16'h0807; exp_w[3] = 16'hAA09;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    cycle(1'b0, 1'b1, 8'hAA, 1'b1);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL simul_drop_count: got %0d want 3", count); end
    checks++; if (dataout !== 16'h0403) begin errors++; $display("FAIL simul_head: got %h want 0403", dataout); end
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_refill_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dataout !== exp_w[i]) begin errors++; $display("FAIL simul_word%0d: got %h want %h", i, dataout, exp_w[i]); end
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_empty_boundary();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (dut.rd_ptr_q !== 2'd0) begin errors++; $display("FAIL spurious_rdptr0: got %0d want 0", dut.rd_ptr_q); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL spurious_count: got %0d want 0", count); end
    cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 1'b1, 8'hC3, 1'b1);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL boundary_count: got %0d want 1", count); end
    checks++; if (dataout !== 16'hC35A) begin errors++; $display("FAIL boundary_dataout: got %h want C35A", dataout); end
    checks++; if (dut.rd_ptr_q !== 2'd0) begin errors++; $display("FAIL boundary_rdptr: got %0d want 0", dut.rd_ptr_q); end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (dut.rd_ptr_q !== 2'd1) begin errors++; $display("FAIL spurious_rdptr1: got %0d want 1", dut.rd_ptr_q); end
    checks++; if (dut.wr_ptr_q !== 2'd1) begin errors++; $display("FAIL spurious_wrptr1: got %0d want 1", dut.wr_ptr_q); end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h33, 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b1);
    checks++; if (dut.slot_q !== 1'b0) begin errors++; $display("FAIL midrst_slot: got %0d want 0", dut.slot_q); end
    cycle(1'b0, 1'b1, 8'h44, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_partial_hidden: empty got %b want 1", empty); end
    cycle(1'b0, 1'b1, 8'h55, 1'b0);
    checks++; if (dataout !== 16'h5544) begin errors++; $display("FAIL midrst_dataout: got %h want 5544", dataout); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL midrst_count: got %0d want 1", count); end
  endtask

  task automatic test_random();
    logic w, r, rs;
    int wr_bias;
    logic [15:0] exp_d;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 800; n++) begin
      wr_bias = ((n / 100) % 2 == 0) ? 80 : 30;
      w  = ($urandom_range(0, 99) < wr_bias);
      r  = ($urandom_range(0, 99) < (110 - wr_bias));
      rs = ($urandom_range(0, 199) == 0);
      cycle(rs, w, 8'($urandom), r);
      exp_d = (mq.size() > 0) ? mq[0] : 16'h0000;
      checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_empty@%0d: got %b want %b", n, empty, (mq.size() == 0)); end
      checks++; if (full !== ((mq.size() == D) && (slot == R - 1))) begin errors++; $display("FAIL rand_full@%0d: got %b want %b", n, full, ((mq.size() == D) && (slot == R - 1))); end
      checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d want %0d", n, count, mq.size()); end
      checks++; if (dataout !== exp_d) begin errors++; $display("FAIL rand_dataout@%0d: got %h want %h", n, dataout, exp_d); end
    end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; datain = '0;
    test_reset();
    test_pack_read();
    test_fill_full();
    test_drain();
    test_simultaneous();
    test_empty_boundary();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
